mux_select_arbiter: RTL and testbench
=====================================

# mux_select_arbiter

Round-robin arbiter and sequencer for the 3-source, 2-bit-select mux datapath.
- Three requesters (sources X, Y, Z) compete for the shared mux output.
- The block owns the S1/S0 select lines and holds each grant for a programmable dwell time.
- It inserts one idle turnaround cycle between grants and produces a registered T output equal to the granted source's data bit.
- It replaces free-running select stimulus with a deterministic, fair schedule.

## Interface
- DWELL, 4: maximum cycles a grant is held. Legal range 1..15; counter width is 4 bits.
- Clk  in  1  system clock; all state updates on the rising edge.
- synch_reset_n  in  1  reset, synchronous, active-low. Sampled only on the rising edge of Clk.
- req  in  3  request vector: bit0 = X, bit1 = Y, bit2 = Z. Level-sensitive.
- X, Y, Z  in  1 each  source data bits.
- S1, S0  out  1 each  registered mux select.
  - 00 = X, 01 = Y, 10 = Z.
  - 11 = idle; the idle input is constant 0.
- gnt  out  3  registered one-hot grant, same bit order as req; 000 when no grant.
- T  out  1  registered data of the source selected in the previous cycle.
- busy  out  1  high while in GRANT or GAP.

## Operation
- States:
  - IDLE: select 11, gnt 000, busy 0.
  - GRANT: select = granted source, gnt one-hot, busy 1.
  - GAP: select 11, gnt 000, busy 1.
- Reset (synch_reset_n = 0 at an edge) forces the following, regardless of current state or any other input:
  - state = IDLE; {S1,S0} = 11; gnt = 000; busy = 0; T = 0.
  - dwell counter = 0; round-robin pointer last = Z, so X has first priority after reset.
- Arbitration happens in IDLE and in GAP. The winner is the first set req bit searching circularly from last+1 (X→Y→Z→X).
- IDLE → GRANT when any req bit = 1. The winner becomes the grant, last = winner, counter = 0.
- GRANT → GAP when either condition holds:
  - counter == DWELL-1 (dwell expired); or
  - req[granted] = 0 (early release).
- In GRANT, the counter increments each cycle. It never exceeds DWELL-1 and never wraps.
- GAP lasts exactly 1 cycle.
  - GAP → GRANT if any req bit = 1, arbitrating with the updated last pointer.
  - GAP → IDLE otherwise.
- The same source may be granted back-to-back, separated by the GAP cycle, only if it is the sole requester.
- T is updated every cycle:
  - T ← X, Y or Z according to the current {S1,S0};
  - T ← 0 when the current select is 11.
- req changes during GRANT for non-granted sources have no effect until the next arbitration.

## Timing
- Request latency: req sampled high at edge n while in IDLE gives gnt/select valid after edge n, i.e. during cycle n+1.
- Data latency: T reflects the granted source one cycle after the select, i.e. during cycle n+2.
- A full dwell holds gnt for exactly DWELL cycles, followed by 1 GAP cycle.
  - Period per grant under continuous contention = DWELL+1 cycles.
- Early release: req[g] sampled low at an edge during GRANT gives gnt = 000 after that edge.
- If release and dwell expiry occur on the same edge, there is a single transition to GAP.
- DWELL = 1: every grant lasts 1 cycle; the select pattern alternates grant/idle.
- Reset asserted mid-GRANT: outputs reach reset values after that edge.
  - First grant after release goes to the lowest set req bit starting at X.
- All outputs are glitch-free registers. No combinational path from req, X, Y or Z to any output.

## Test plan
- Reset: hold synch_reset_n = 0 for 3 edges with req = 111 → S1S0 = 11, gnt = 000, busy = 0, T = 0 throughout; first grant after release = X.
- Fairness: DWELL = 4, req = 111 constant → grant order X, Y, Z, X, … with 4 grant cycles and 1 GAP per source; select sequence 00×4, 11, 01×4, 11, 10×4, 11.
- Early release: grant Y, drop req[1] after 2 grant cycles → gnt 010 for 2 cycles, then GAP, then the next requester or IDLE.
- Data path: grant Z with Z toggling each cycle → T equals Z delayed one cycle during grant; T = 0 one cycle after any idle select.
- Sole requester: only req[0] = 1, DWELL = 2 → pattern 00, 00, 11 repeating; T = 0 during the cycle after each GAP.
- Mid-operation reset: assert synch_reset_n = 0 during the 3rd cycle of a Y grant → next cycle all outputs are at reset values; after release with req = 110, the first grant is Y.

Source files
------------

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter and sequencer for the three-source, two-bit-select mux.
// Each grant is held for up to DWELL cycles, with one idle turnaround cycle between grants.
module mux_select_arbiter #(
    parameter int DWELL = 4
) (
    input  logic       Clk,
    input  logic       synch_reset_n,
    input  logic [2:0] req,
    input  logic       X,
    input  logic       Y,
    input  logic       Z,
    output logic       S1,
    output logic       S0,
    output logic [2:0] gnt,
    output logic       T,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
    localparam logic [1:0] SEL_IDLE   = 2'b11;
    localparam logic [1:0] SRC_Z      = 2'd2;

    state_t     state_reg;
    logic [1:0] last_reg;
    logic [3:0] cnt_reg;
    logic [1:0] sel_reg;
    logic [2:0] gnt_reg;
    logic       busy_reg;
    logic       t_reg;

    logic       any_req;
    logic [1:0] winner;
    logic       t_next;

    assign any_req = |req;

    // One fixed-priority search per possible value of last. Block gi starts
    // at the source after gi and visits gi itself last.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rot
            localparam int P0 = (gi + 1) % 3;
            localparam int P1 = (gi + 2) % 3;
            localparam int P2 = gi;
            logic [1:0] win;
            assign win = req[P0] ? 2'(P0) :
                         req[P1] ? 2'(P1) : 2'(P2);
        end
    endgenerate

    always_comb begin
        winner = g_rot[2].win;
        case (last_reg)
            2'd0:    winner = g_rot[0].win;
            2'd1:    winner = g_rot[1].win;
            default: winner = g_rot[2].win;
        endcase
    end

    // T follows whichever source the registered select is driving now.
    always_comb begin
        t_next = 1'b0;
        case (sel_reg)
            2'b00:   t_next = X;
            2'b01:   t_next = Y;
            2'b10:   t_next = Z;
            default: t_next = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!synch_reset_n) begin
            state_reg <= ST_IDLE;
            last_reg  <= SRC_Z;
            cnt_reg   <= 4'd0;
            sel_reg   <= SEL_IDLE;
            gnt_reg   <= 3'b000;
            busy_reg  <= 1'b0;
            t_reg     <= 1'b0;
        end else begin
            t_reg <= t_next;
            case (state_reg)
                ST_IDLE, ST_GAP: begin
                    if (any_req) begin
                        state_reg <= ST_GRANT;
                        last_reg  <= winner;
                        cnt_reg   <= 4'd0;
                        sel_reg   <= winner;
                        gnt_reg   <= 3'b001 << winner;
                        busy_reg  <= 1'b1;
                    end else begin
                        state_reg <= ST_IDLE;
                        sel_reg   <= SEL_IDLE;
                        gnt_reg   <= 3'b000;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // last_reg always names the source currently holding the grant.
                    if (cnt_reg == DWELL_LAST || !req[last_reg]) begin
                        state_reg <= ST_GAP;
                        sel_reg   <= SEL_IDLE;
                        gnt_reg   <= 3'b000;
                        busy_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    sel_reg   <= SEL_IDLE;
                    gnt_reg   <= 3'b000;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign S1   = sel_reg[1];
    assign S0   = sel_reg[0];
    assign gnt  = gnt_reg;
    assign busy = busy_reg;
    assign T    = t_reg;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench for mux_select_arbiter: directed vectors push expected outputs,
// and a monitor pops one entry after every rising edge and compares.
module tb_mux_select_arbiter;

    logic       Clk;
    logic       rn0, rn1;
    logic [2:0] req0, req1;
    logic       x0, y0, z0, x1, y1, z1;
    logic       s1_0, s0_0, s1_1, s0_1;
    logic [2:0] gnt0, gnt1;
    logic       t0, t1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         u;
        logic [6:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];

    mux_select_arbiter #(.DWELL(4)) dut (
        .Clk(Clk), .synch_reset_n(rn0), .req(req0),
        .X(x0), .Y(y0), .Z(z0),
        .S1(s1_0), .S0(s0_0), .gnt(gnt0), .T(t0), .busy(busy0)
    );

    mux_select_arbiter #(.DWELL(2)) dut2 (
        .Clk(Clk), .synch_reset_n(rn1), .req(req1),
        .X(x1), .Y(y1), .Z(z1),
        .S1(s1_1), .S0(s0_1), .gnt(gnt1), .T(t1), .busy(busy1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic step(input string nm, input int rep, input bit u, input bit rn,
                        input logic [2:0] rq, input logic x, input logic y, input logic z,
                        input logic [1:0] esel, input logic [2:0] egnt,
                        input logic eb, input logic et);
        for (int i = 0; i < rep; i++) begin
            @(negedge Clk);
            if (!u) begin
                rn0 = rn; req0 = rq; x0 = x; y0 = y; z0 = z;
            end else begin
                rn1 = rn; req1 = rq; x1 = x; y1 = y; z1 = z;
            end
            q.push_back('{u, {esel, egnt, eb, et}, nm});
        end
    endtask

    // Monitor: every cycle is an output beat for the unit named in the entry.
    initial begin
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = e.u ? {s1_1, s0_1, gnt1, busy1, t1} : {s1_0, s0_0, gnt0, busy0, t0};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s (unit %0d): got sel=%b gnt=%b busy=%b T=%b, expected sel=%b gnt=%b busy=%b T=%b",
                             e.name, e.u, act[6:5], act[4:2], act[1], act[0],
                             e.exp[6:5], e.exp[4:2], e.exp[1], e.exp[0]);
                end else begin
                    $display("check %s (unit %0d): sel=%b gnt=%b busy=%b T=%b", e.name, e.u,
                             act[6:5], act[4:2], act[1], act[0]);
                end
            end
        end
    end

    initial begin
        rn0 = 1'b0; rn1 = 1'b0;
        req0 = 3'b000; req1 = 3'b000;
        x0 = 1'b0; y0 = 1'b0; z0 = 1'b0;
        x1 = 1'b0; y1 = 1'b0; z1 = 1'b0;

        // Reset held with all requests and data high
        step("reset",          3, 0, 0, 3'b111, 1, 1, 1, 2'b11, 3'b000, 0, 0);
        // Fairness, DWELL=4, X=1 Y=0 Z=1
        step("fair_x_first",   1, 0, 1, 3'b111, 1, 0, 1, 2'b00, 3'b001, 1, 0);
        step("fair_x_hold",    3, 0, 1, 3'b111, 1, 0, 1, 2'b00, 3'b001, 1, 1);
        step("fair_gap1",      1, 0, 1, 3'b111, 1, 0, 1, 2'b11, 3'b000, 1, 1);
        step("fair_y_first",   1, 0, 1, 3'b111, 1, 0, 1, 2'b01, 3'b010, 1, 0);
        step("fair_y_hold",    3, 0, 1, 3'b111, 1, 0, 1, 2'b01, 3'b010, 1, 0);
        step("fair_gap2",      1, 0, 1, 3'b111, 1, 0, 1, 2'b11, 3'b000, 1, 0);
        step("fair_z_first",   1, 0, 1, 3'b111, 1, 0, 1, 2'b10, 3'b100, 1, 0);
        step("fair_z_hold",    3, 0, 1, 3'b111, 1, 0, 1, 2'b10, 3'b100, 1, 1);
        step("fair_gap3",      1, 0, 1, 3'b111, 1, 0, 1, 2'b11, 3'b000, 1, 1);
        step("fair_x2_first",  1, 0, 1, 3'b111, 1, 0, 1, 2'b00, 3'b001, 1, 0);
        step("fair_x2_hold",   3, 0, 1, 3'b111, 1, 0, 1, 2'b00, 3'b001, 1, 1);
        step("fair_gap4",      1, 0, 1, 3'b111, 1, 0, 1, 2'b11, 3'b000, 1, 1);
        // Early release of Y after two grant cycles, then Z takes over
        step("early_y",        2, 0, 1, 3'b111, 1, 0, 1, 2'b01, 3'b010, 1, 0);
        step("early_rel",      1, 0, 1, 3'b101, 1, 0, 1, 2'b11, 3'b000, 1, 0);
        step("early_next_z",   1, 0, 1, 3'b101, 1, 0, 1, 2'b10, 3'b100, 1, 0);
        step("rel_z",          1, 0, 1, 3'b000, 1, 0, 1, 2'b11, 3'b000, 1, 1);
        step("to_idle",        1, 0, 1, 3'b000, 1, 0, 1, 2'b11, 3'b000, 0, 0);
        step("idle",           1, 0, 1, 3'b000, 1, 0, 1, 2'b11, 3'b000, 0, 0);
        // Data path: Z toggling while granted
        step("dp_grant",       1, 0, 1, 3'b100, 1, 0, 0, 2'b10, 3'b100, 1, 0);
        step("dp_t1",          1, 0, 1, 3'b100, 1, 0, 1, 2'b10, 3'b100, 1, 1);
        step("dp_t0",          1, 0, 1, 3'b100, 1, 0, 0, 2'b10, 3'b100, 1, 0);
        step("dp_t1b",         1, 0, 1, 3'b100, 1, 0, 1, 2'b10, 3'b100, 1, 1);
        step("dp_gap",         1, 0, 1, 3'b100, 1, 0, 0, 2'b11, 3'b000, 1, 0);
        step("dp_regrant",     1, 0, 1, 3'b100, 1, 0, 1, 2'b10, 3'b100, 1, 0);
        step("dp_t1c",         1, 0, 1, 3'b100, 1, 0, 1, 2'b10, 3'b100, 1, 1);
        step("dp_rel",         1, 0, 1, 3'b000, 1, 0, 0, 2'b11, 3'b000, 1, 0);
        step("dp_idle",        1, 0, 1, 3'b000, 1, 0, 1, 2'b11, 3'b000, 0, 0);
        // Reset during the third cycle of a Y grant; then req=110 must pick Y
        step("mr_grant_y",     1, 0, 1, 3'b010, 0, 1, 0, 2'b01, 3'b010, 1, 0);
        step("mr_y_hold",      2, 0, 1, 3'b010, 0, 1, 0, 2'b01, 3'b010, 1, 1);
        step("mr_reset",       1, 0, 0, 3'b010, 0, 1, 0, 2'b11, 3'b000, 0, 0);
        step("mr_first_y",     1, 0, 1, 3'b110, 0, 1, 0, 2'b01, 3'b010, 1, 0);
        step("mr_rel",         1, 0, 1, 3'b000, 0, 1, 0, 2'b11, 3'b000, 1, 1);
        step("mr_idle",        1, 0, 1, 3'b000, 0, 1, 0, 2'b11, 3'b000, 0, 0);
        // Sole requester X on the DWELL=2 instance
        step("s_reset",        1, 1, 0, 3'b001, 1, 0, 0, 2'b11, 3'b000, 0, 0);
        step("s_grant",        1, 1, 1, 3'b001, 1, 0, 0, 2'b00, 3'b001, 1, 0);
        step("s_hold",         1, 1, 1, 3'b001, 1, 0, 0, 2'b00, 3'b001, 1, 1);
        step("s_gap",          1, 1, 1, 3'b001, 1, 0, 0, 2'b11, 3'b000, 1, 1);
        step("s_regrant",      1, 1, 1, 3'b001, 1, 0, 0, 2'b00, 3'b001, 1, 0);
        step("s_hold2",        1, 1, 1, 3'b001, 1, 0, 0, 2'b00, 3'b001, 1, 1);
        step("s_gap2",         1, 1, 1, 3'b001, 1, 0, 0, 2'b11, 3'b000, 1, 1);
        step("s_regrant2",     1, 1, 1, 3'b001, 1, 0, 0, 2'b00, 3'b001, 1, 0);
        step("s_rel",          1, 1, 1, 3'b000, 1, 0, 0, 2'b11, 3'b000, 1, 1);
        step("s_idle",         1, 1, 1, 3'b000, 1, 0, 0, 2'b11, 3'b000, 0, 0);

        @(posedge Clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
